vector_store_serializer: RTL and testbench
==========================================

Name: vector_store_serializer

Overview:
- Downstream consumer of the lane router's 128-bit vector output for vector store instructions.
- Accepts one 4-lane vector, a base address and a lane mask.
- Issues one 32-bit word write per enabled lane to the 32-bit data memory port, in ascending lane order, holding each beat until the memory acknowledges it.
- Pulses done when the whole vector has been written, so the core pipeline can release the store.

Parameters:
- LANES, 4, number of 32-bit lanes in a vector.
- LANE_W, 32, lane and memory data width in bits.
- ADDR_W, 32, byte address width.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  a store request is presented.
- req_ready  output  1  block is idle and can accept a request.
- req_vector  input  LANES*LANE_W  vector data; lane i is bits [32i+31:32i].
- req_addr  input  ADDR_W  byte address of lane 0.
- req_lane_mask  input  LANES  bit i=1 means lane i is written.
- mem_we  output  1  write beat is valid.
- mem_addr  output  ADDR_W  word-aligned byte address of the current beat.
- mem_wdata  output  LANE_W  data for the current beat.
- mem_ack  input  1  memory accepts the current beat this cycle.
- busy  output  1  a request is in progress (not IDLE).
- done  output  1  one-cycle pulse when the request completes.

Behaviour:
- States: IDLE, WRITE, DONE.
- Reset (asynchronous, any cycle, including mid-request):
  - State goes to IDLE.
  - req_ready=1 after reset release; mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0.
  - All captured registers clear to 0.
  - Any pending beat is abandoned and no done pulse is produced.
- IDLE:
  - req_ready=1, busy=0.
  - A handshake is req_valid=1 and req_ready=1 at a rising edge.
  - On handshake, capture vector, req_addr with bits [1:0] forced to 0, and the mask.
  - If the mask is non-zero, go to WRITE, selecting the lowest enabled lane.
  - If the mask is all zeros, go directly to DONE; no memory beats are issued.
- WRITE:
  - req_ready=0, busy=1, mem_we=1.
  - mem_addr = captured base + 4*lane, modulo 2^ADDR_W (wraps, no error).
  - mem_wdata = captured lane data.
  - Outputs stay stable until mem_ack=1 is sampled.
  - On ack, advance to the next higher enabled lane; disabled lanes cost zero cycles.
  - On ack of the highest enabled lane, go to DONE.
- DONE:
  - done=1 for exactly one cycle; mem_we=0, req_ready=0, busy=1.
  - Next state is IDLE.
- Latency with mem_ack tied high:
  - Handshake at edge T; first beat visible in cycle T+1.
  - Full mask: beats in cycles T+1..T+4, done in T+5, req_ready=1 in T+6.
  - Empty mask: done in T+1.
- Throughput: minimum turnaround is one request per (enabled lanes + 2) cycles.
- mem_ack while mem_we=0 is ignored.
- req_valid while not in IDLE is ignored; inputs are not captured.
- Input changes after the handshake have no effect, because everything is captured at the handshake.
- mem_ack held high for several cycles: exactly one beat is retired per cycle.

Decomposition:
- Shared package vector_pkg holds:
  - LANES, LANE_W, VEC_W = LANES*LANE_W, LANE_IDX_W = $clog2(LANES).
  - Enum for the serializer state (IDLE, WRITE, DONE).
  - Lane-slice helper function.
- One sub-module, next_lane_finder, is combinational and reused by the router-side control:
  - Inputs: mask, current index.
  - Outputs: next enabled index above the current one, and a "last" flag.
  - Also used at capture with a "from start" input to select the lowest enabled lane.

Test Plan:
- Full mask:
  - Stimulus: mask=4'b1111, addr=0x1000, vector lanes {0xDDDD0003, 0xCCCC0002, 0xBBBB0001, 0xAAAA0000} (lane3..lane0), mem_ack tied 1.
  - Response: beats (0x1000, 0xAAAA0000), (0x1004, 0xBBBB0001), (0x1008, 0xCCCC0002), (0x100C, 0xDDDD0003) in cycles T+1..T+4; done=1 only in T+5.
- Sparse mask with stalls:
  - Stimulus: mask=4'b1010, addr=0x2000, mem_ack delayed 2 cycles per beat.
  - Response: only 0x2004 (lane1) then 0x200C (lane3); each beat held 3 cycles with stable data; done one cycle after the second ack.
- Empty mask:
  - Stimulus: mask=0.
  - Response: mem_we never asserts; done=1 in T+1; req_ready=1 in T+2.
- Wrap and alignment:
  - Stimulus: addr=0xFFFFFFFB, full mask.
  - Response: mem_addr sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
- Reset mid-request:
  - Stimulus: assert rst while the lane-2 beat is pending.
  - Response: mem_we=0 immediately (asynchronous), no done pulse, req_ready=1 after release; the next request with mask=4'b0001 completes normally.
- Busy-time request:
  - Stimulus: pulse req_valid with new data during WRITE.
  - Response: ignored; only the original request's beats appear, followed by a single done.

Source files
------------

// File: rtl/vector_pkg.sv
// Shared vector-datapath definitions: lane geometry, serializer state encoding
// and the lane-slice helper used by the store path.
package vector_pkg;

  localparam int unsigned LANES      = 4;
  localparam int unsigned LANE_W     = 32;
  localparam int unsigned VEC_W      = LANES * LANE_W;
  localparam int unsigned LANE_IDX_W = $clog2(LANES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } ser_state_e;

  function automatic logic [LANE_W-1:0] lane_slice(
    input logic [VEC_W-1:0]      vec,
    input logic [LANE_IDX_W-1:0] idx
  );
    return vec[idx*LANE_W +: LANE_W];
  endfunction

endpackage

// File: rtl/next_lane_finder.sv
// Combinational search for the next enabled lane. With from_start_i the search
// includes lane 0; otherwise it covers lanes strictly above cur_idx_i.
module next_lane_finder #(
  parameter int unsigned LANES = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [LANES-1:0] mask_i,
  input  logic [IDX_W-1:0] cur_idx_i,
  input  logic             from_start_i,
  output logic [IDX_W-1:0] next_idx_o,
  output logic             last_o
);

  logic found;

  always_comb begin
    found      = 1'b0;
    next_idx_o = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (!found && mask_i[i] && (from_start_i || (i > int'(cur_idx_i)))) begin
        found      = 1'b1;
        next_idx_o = i[IDX_W-1:0];
      end
    end
    // No enabled lane in the search range: the current lane was the last one
    // (or, when searching from the start, the mask is empty).
    last_o = !found;
  end

endmodule

// File: rtl/vector_store_serializer.sv
// Serializes one captured 4-lane vector into 32-bit memory write beats, one per
// enabled lane in ascending order, then pulses done for a single cycle.
module vector_store_serializer #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned LANE_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [LANES*LANE_W-1:0] req_vector,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [LANES-1:0]        req_lane_mask,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [LANE_W-1:0]       mem_wdata,
  input  logic                    mem_ack,
  output logic                    busy,
  output logic                    done
);

  import vector_pkg::*;

  localparam int unsigned IDX_W = $clog2(LANES);

  ser_state_e              state_q, state_d;
  logic [LANES*LANE_W-1:0] vec_q, vec_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [LANES-1:0]        mask_q, mask_d;
  logic [IDX_W-1:0]        idx_q, idx_d;

  logic [IDX_W-1:0]        first_idx, next_idx;
  logic                    mask_empty, cur_last;

  next_lane_finder #(.LANES(LANES), .IDX_W(IDX_W)) u_first (
    .mask_i       (req_lane_mask),
    .cur_idx_i    ('0),
    .from_start_i (1'b1),
    .next_idx_o   (first_idx),
    .last_o       (mask_empty)
  );

  next_lane_finder #(.LANES(LANES), .IDX_W(IDX_W)) u_next (
    .mask_i       (mask_q),
    .cur_idx_i    (idx_q),
    .from_start_i (1'b0),
    .next_idx_o   (next_idx),
    .last_o       (cur_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      base_q  <= '0;
      mask_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      base_q  <= base_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    base_d    = base_q;
    mask_d    = mask_q;
    idx_d     = idx_q;
    req_ready = 1'b0;
    busy      = 1'b1;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    done      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          vec_d   = req_vector;
          base_d  = {req_addr[ADDR_W-1:2], 2'b00};
          mask_d  = req_lane_mask;
          idx_d   = first_idx;
          state_d = mask_empty ? ST_DONE : ST_WRITE;
        end
      end
      ST_WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = base_q + (ADDR_W'(idx_q) << 2);
        mem_wdata = lane_slice(vec_q, idx_q);
        if (mem_ack) begin
          if (cur_last) state_d = ST_DONE;
          else          idx_d   = next_idx;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_vector_store_serializer.sv
// Self-checking bench: directed and random store requests checked cycle by cycle
// against a beat-list model built from the mask, base address and lane data.
module tb_vector_store_serializer;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [127:0] req_vector;
  logic [31:0]  req_addr;
  logic [3:0]   req_lane_mask;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_ack;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;

  vector_store_serializer #(.LANES(4), .LANE_W(32), .ADDR_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_vector    (req_vector),
    .req_addr      (req_addr),
    .req_lane_mask (req_lane_mask),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Issues one request at the current negedge and checks every following cycle.
  // stall < 0 picks a random 0..2 cycle ack delay per beat.
  task automatic run_req(input logic [31:0] addr, input logic [127:0] vec,
                         input logic [3:0] mask, input int stall, input bit busy_poke);
    logic [63:0] q[$];
    logic [31:0] ea;
    int waited, cur_stall, cyc;
    for (int l = 0; l < 4; l++) begin
      if (mask[l]) begin
        ea = (addr & 32'hFFFF_FFFC) + 32'(4 * l);
        q.push_back({ea, vec[l*32 +: 32]});
      end
    end
    check("ready_before_req", 64'(req_ready), 64'(1));
    req_valid     = 1'b1;
    req_addr      = addr;
    req_vector    = vec;
    req_lane_mask = mask;
    mem_ack       = 1'($urandom_range(0, 1));
    @(negedge clk);
    req_valid     = 1'b0;
    req_addr      = $urandom;
    req_vector    = rand_vec();
    req_lane_mask = 4'($urandom);
    waited = 0;
    cur_stall = 0;
    cyc = 0;
    while (q.size() > 0) begin
      check("beat_we",     64'(mem_we),    64'(1));
      check("beat_addr",   64'(mem_addr),  64'(q[0][63:32]));
      check("beat_wdata",  64'(mem_wdata), 64'(q[0][31:0]));
      check("beat_busy",   64'(busy),      64'(1));
      check("beat_ready",  64'(req_ready), 64'(0));
      check("beat_done",   64'(done),      64'(0));
      if (waited == 0) cur_stall = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
      if (waited == cur_stall) begin
        mem_ack = 1'b1;
        void'(q.pop_front());
        waited = 0;
      end else begin
        mem_ack = 1'b0;
        waited++;
      end
      req_valid = busy_poke && (cyc == 1);
      if (req_valid) begin
        req_addr      = $urandom;
        req_vector    = rand_vec();
        req_lane_mask = 4'hF;
      end
      cyc++;
      @(negedge clk);
    end
    check("done_pulse",   64'(done),      64'(1));
    check("done_we",      64'(mem_we),    64'(0));
    check("done_busy",    64'(busy),      64'(1));
    check("done_ready",   64'(req_ready), 64'(0));
    mem_ack   = 1'($urandom_range(0, 1));
    req_valid = busy_poke;
    @(negedge clk);
    req_valid = 1'b0;
    mem_ack   = 1'b0;
    check("idle_done",  64'(done),      64'(0));
    check("idle_ready", 64'(req_ready), 64'(1));
    check("idle_busy",  64'(busy),      64'(0));
    check("idle_we",    64'(mem_we),    64'(0));
  endtask

  initial begin
    rst           = 1'b1;
    req_valid     = 1'b0;
    req_vector    = '0;
    req_addr      = '0;
    req_lane_mask = '0;
    mem_ack       = 1'b0;
    @(negedge clk);
    check("rst_we",    64'(mem_we),    64'(0));
    check("rst_addr",  64'(mem_addr),  64'(0));
    check("rst_wdata", 64'(mem_wdata), 64'(0));
    check("rst_busy",  64'(busy),      64'(0));
    check("rst_done",  64'(done),      64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'(1));

    // Full mask, ack tied high
    run_req(32'h0000_1000, {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000},
            4'b1111, 0, 1'b0);
    // Sparse mask with two stall cycles per beat
    run_req(32'h0000_2000, rand_vec(), 4'b1010, 2, 1'b0);
    // Empty mask
    run_req(32'h0000_3000, rand_vec(), 4'b0000, 0, 1'b0);
    // Unaligned base with address wrap
    run_req(32'hFFFF_FFFB, rand_vec(), 4'b1111, 0, 1'b0);
    // Request poked while busy
    run_req(32'h0000_4000, rand_vec(), 4'b1111, 1, 1'b1);

    // Reset while the lane-2 beat is pending
    req_valid     = 1'b1;
    req_addr      = 32'h0000_5000;
    req_vector    = rand_vec();
    req_lane_mask = 4'b1111;
    mem_ack       = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_we",   64'(mem_we),   64'(1));
    check("pre_rst_addr", 64'(mem_addr), 64'(32'h0000_5008));
    mem_ack = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("async_rst_we",    64'(mem_we),    64'(0));
    check("async_rst_addr",  64'(mem_addr),  64'(0));
    check("async_rst_wdata", 64'(mem_wdata), 64'(0));
    check("async_rst_busy",  64'(busy),      64'(0));
    check("async_rst_done",  64'(done),      64'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_done",  64'(done),      64'(0));
      check("post_rst_we",    64'(mem_we),    64'(0));
      check("post_rst_ready", 64'(req_ready), 64'(1));
    end
    run_req($urandom, rand_vec(), 4'b0001, 0, 1'b0);

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      run_req($urandom, rand_vec(), 4'($urandom), -1, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
